dmem_arb: RTL and testbench

- Two-port arbiter and sequencer in front of the word-wide data memory (`dmem`). Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- Serialises both requesters onto the single memory port.
- Turns byte and halfword stores into a two-cycle read-modify-write, because the memory can only write whole words.
- Returns sign-extended load data, using the memory's own sub-word extraction.

---
 rtl/dmem_arb.sv | 76 +++++++
 tb/tb_dmem_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: 2-port arbiter/sequencer onto one word-wide dmem (req/we/a/wd/bytes per port in; ack/err/rd/busy out; mem_* drive dmem, mem_rd/mem_rawd return)
module dmem_arb #(
  parameter int FIXED_PRIO = 0,
  parameter int MEM_WORDS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  logic [1:0]  bytes0,
  input  logic [1:0]  bytes1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rd,
  output logic        busy,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_bytes,
  input  logic [31:0] mem_rd,
  input  logic [31:0] mem_rawd
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP} state_t;
  state_t state, state_n, idle_n;
  logic owner, err_q, last_grant, gnt, gwe, oob;
  logic [31:0] ga, gwd, merge;
  logic [1:0] gb;
  always_comb begin
    gnt = &req ? (FIXED_PRIO != 0 ? 1'b0 : ~last_grant) : req[1];
    ga = gnt ? a1 : a0;
    gwd = gnt ? wd1 : wd0;
    gwe = gnt ? we1 : we0;
    gb = gnt ? bytes1 : bytes0;
    oob = {2'b00, ga[31:2]} >= 32'(MEM_WORDS);
    idle_n = !(|req) ? IDLE : oob ? RESP : !gwe ? READ : (gb == 2'd1 || gb == 2'd2) ? RMW_RD : WRITE;
    state_n = state == IDLE ? idle_n : state == RMW_RD ? RMW_WR : state == RESP ? IDLE : RESP;
    merge = mem_rawd;
    if (mem_bytes == 2'd1) merge[{mem_a[1:0], 3'b000} +: 8] = mem_wd[7:0];
    else merge[{mem_a[1], 4'b0000} +: 16] = mem_wd[15:0];
  end
  assign busy = state != IDLE;
  assign mem_we = state == WRITE || state == RMW_WR;
  assign ack = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign err = state == RESP && err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      err_q <= 1'b0;
      last_grant <= 1'b1;
      rd <= '0;
      mem_a <= '0;
      mem_wd <= '0;
      mem_bytes <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) begin
        owner <= gnt;
        last_grant <= gnt;
        err_q <= oob;
        if (!oob) begin
          mem_a <= ga;
          mem_wd <= gwd;
          mem_bytes <= gb;
        end
      end
      if (state == READ) rd <= mem_rd;
      if (state == RMW_RD) mem_wd <= merge;
    end
  end
endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: randomized and directed checks of dmem_arb (round-robin and fixed-priority instances) against a transaction-level reference
module tb_dmem_arb;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req [2];
  logic [1:0] ack [2];
  logic [1:0] bytes0 [2];
  logic [1:0] bytes1 [2];
  logic [1:0] mem_bytes [2];
  logic we0 [2];
  logic we1 [2];
  logic err [2];
  logic busy [2];
  logic mem_we [2];
  logic [31:0] a0 [2];
  logic [31:0] a1 [2];
  logic [31:0] wd0 [2];
  logic [31:0] wd1 [2];
  logic [31:0] rd [2];
  logic [31:0] mem_a [2];
  logic [31:0] mem_wd [2];
  logic [31:0] mem_rd [2];
  logic [31:0] mem_rawd [2];
  logic [31:0] mem [2][64] = '{default: '0};
  logic [31:0] ref_mem [2][64] = '{default: '0};
  logic [31:0] ref_rd [2];
  int last_g [2];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : dut
    dmem_arb #(.FIXED_PRIO(g), .MEM_WORDS(64)) u (
      .clk(clk), .reset(reset), .req(req[g]),
      .we0(we0[g]), .we1(we1[g]), .a0(a0[g]), .a1(a1[g]),
      .wd0(wd0[g]), .wd1(wd1[g]), .bytes0(bytes0[g]), .bytes1(bytes1[g]),
      .ack(ack[g]), .err(err[g]), .rd(rd[g]), .busy(busy[g]),
      .mem_we(mem_we[g]), .mem_a(mem_a[g]), .mem_wd(mem_wd[g]), .mem_bytes(mem_bytes[g]),
      .mem_rd(mem_rd[g]), .mem_rawd(mem_rawd[g])
    );
  end
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] a, input logic [1:0] b);
    logic [31:0] s;
    if (b == 2'd1) begin
      s = w >> (8 * int'(a[1:0]));
      return {{24{s[7]}}, s[7:0]};
    end
    if (b == 2'd2) begin
      s = w >> (a[1] ? 16 : 0);
      return {{16{s[15]}}, s[15:0]};
    end
    return w;
  endfunction
  function automatic logic [31:0] store_ref(input logic [31:0] w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] b);
    int sh;
    logic [31:0] m;
    sh = b == 2'd1 ? 8 * int'(a[1:0]) : b == 2'd2 ? (a[1] ? 16 : 0) : 0;
    m = b == 2'd1 ? 32'hFF << sh : b == 2'd2 ? 32'hFFFF << sh : 32'hFFFF_FFFF;
    return (w & ~m) | ((wd << sh) & m);
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (mem_we[k]) mem[k][mem_a[k][7:2]] <= mem_wd[k];
  always_comb
    for (int k = 0; k < 2; k++) begin
      mem_rawd[k] = mem[k][mem_a[k][7:2]];
      mem_rd[k] = ext(mem_rawd[k], mem_a[k], mem_bytes[k]);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_port(input int k, input int p, input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] b);
    if (p == 0) begin
      we0[k] = w; a0[k] = a; wd0[k] = wd; bytes0[k] = b;
    end else begin
      we1[k] = w; a1[k] = a; wd1[k] = wd; bytes1[k] = b;
    end
  endtask
  task automatic op(input int k, input int p, input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] b, output logic [31:0] got);
    int n = 0;
    int lat;
    logic saw_we = 1'b0;
    logic oob;
    set_port(k, p, w, a, wd, b);
    req[k][p] = 1'b1;
    do begin
      @(negedge clk);
      n++;
      saw_we |= mem_we[k];
    end while (ack[k] == 2'b00 && n < 10);
    req[k][p] = 1'b0;
    oob = a[31:8] != 0;
    lat = oob ? 1 : !w ? 2 : (b == 2'd1 || b == 2'd2) ? 3 : 2;
    last_g[k] = p;
    chk("latency", n, lat);
    chk("ack_port", ack[k], 32'(1 << p));
    chk("err", err[k], oob);
    chk("busy_resp", busy[k], 1);
    if (oob) chk("err_no_we", saw_we, 0);
    else if (w) begin
      ref_mem[k][a[7:2]] = store_ref(ref_mem[k][a[7:2]], a, wd, b);
      chk("mem_word", mem[k][a[7:2]], ref_mem[k][a[7:2]]);
    end else ref_rd[k] = ext(ref_mem[k][a[7:2]], a, b);
    chk("rd", rd[k], ref_rd[k]);
    got = rd[k];
    repeat (2) @(negedge clk);
  endtask
  task automatic tie(input int k);
    int n = 0;
    int first;
    first = k == 1 ? 0 : 1 - last_g[k];
    set_port(k, 0, 1'b0, 32'h0, 32'h0, 2'd0);
    set_port(k, 1, 1'b0, 32'h0, 32'h0, 2'd0);
    req[k] = 2'b11;
    do begin
      @(negedge clk);
      n++;
    end while (ack[k] == 2'b00 && n < 10);
    chk("tie_first", ack[k], 32'(1 << first));
    req[k][first] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[k] == 2'b00 && n < 10);
    chk("tie_second", ack[k], 32'(1 << (1 - first)));
    req[k] = 2'b00;
    last_g[k] = 1 - first;
    ref_rd[k] = ref_mem[k][0];
    chk("tie_rd", rd[k], ref_rd[k]);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] g;
    logic [31:0] ra;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 2'b00;
      set_port(k, 0, 1'b0, 32'h0, 32'h0, 2'd0);
      set_port(k, 1, 1'b0, 32'h0, 32'h0, 2'd0);
      ref_rd[k] = '0;
      last_g[k] = 1;
    end
    @(negedge clk);
    chk("rst_ack", ack[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_rd", rd[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_mem_we", mem_we[0], 0);
    chk("rst_mem_a", mem_a[0], 0);
    chk("rst_mem_wd", mem_wd[0], 0);
    chk("rst_mem_bytes", mem_bytes[0], 0);
    chk("rst_busy1", busy[1], 0);
    reset = 1'b0;
    @(negedge clk);
    tie(0);
    op(0, 0, 1'b0, 32'h4, 32'h0, 2'd0, g);
    tie(0);
    tie(0);
    op(0, 1, 1'b0, 32'h4, 32'h0, 2'd0, g);
    tie(0);
    tie(1);
    op(1, 1, 1'b0, 32'h4, 32'h0, 2'd0, g);
    tie(1);
    op(1, 0, 1'b0, 32'h4, 32'h0, 2'd0, g);
    tie(1);
    op(0, 0, 1'b1, 32'h8, 32'hDEADBEEF, 2'd0, g);
    op(0, 0, 1'b0, 32'h8, 32'h0, 2'd0, g);
    chk("tp_word_load", g, 32'hDEADBEEF);
    op(0, 0, 1'b1, 32'h10, 32'h11223344, 2'd0, g);
    op(0, 1, 1'b1, 32'h12, 32'hAB, 2'd1, g);
    op(0, 0, 0, 32'h10, 32'h0, 2'd0, g);
    chk("tp_byte_merge", g, 32'h11AB3344);
    op(0, 1, 1'b0, 32'h12, 32'h0, 2'd1, g);
    chk("tp_byte_load", g, 32'hFFFFFFAB);
    op(0, 0, 1'b0, 32'h10, 32'h0, 2'd2, g);
    chk("tp_half_load_lo", g, 32'h00003344);
    op(0, 0, 1'b1, 32'h10, 32'h11223344, 2'd0, g);
    op(0, 1, 1'b1, 32'h12, 32'h8001, 2'd2, g);
    op(0, 0, 1'b0, 32'h10, 32'h0, 2'd0, g);
    chk("tp_half_merge", g, 32'h80013344);
    op(0, 0, 1'b0, 32'h12, 32'h0, 2'd2, g);
    chk("tp_half_load_hi", g, 32'hFFFF8001);
    op(0, 0, 1'b1, 32'hFC, 32'hCAFEF00D, 2'd0, g);
    op(0, 1, 1'b0, 32'hFC, 32'h0, 2'd0, g);
    chk("tp_last_word", g, 32'hCAFEF00D);
    op(0, 1, 1'b1, 32'h100, 32'h12345678, 2'd0, g);
    op(0, 0, 1'b0, 32'h100, 32'h0, 2'd0, g);
    chk("tp_err_rd_held", g, 32'hCAFEF00D);
    for (int i = 0; i < 60; i++) begin
      ra = $urandom_range(0, 9) == 0 ? (32'h100 | $urandom) : 32'($urandom_range(0, 63));
      op(0, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)), g);
    end
    op(0, 0, 1'b1, 32'h20, 32'h11223344, 2'd0, g);
    set_port(0, 1, 1'b1, 32'h21, 32'h55, 2'd1);
    req[0][1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pre_we", mem_we[0], 1);
    reset = 1'b1;
    #1;
    chk("rst_we_drop", mem_we[0], 0);
    chk("rst_busy_drop", busy[0], 0);
    chk("rst_no_ack", ack[0], 0);
    req[0] = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    last_g[0] = 1;
    last_g[1] = 1;
    chk("rst_word_kept", mem[0][8], 32'h11223344);
    chk("rst_rd_clear", rd[0], 0);
    @(negedge clk);
    chk("rst_idle", busy[0], 0);
    op(0, 0, 1'b0, 32'h20, 32'h0, 2'd0, g);
    tie(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
